// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings driven by the control unit
//   - FSM state encoding
//   - small decode helpers on the op code
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear selects the signed flavour of both MULT and DIV.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake between the control unit and the
// multiply/divide unit.
//   master (control unit): drives start, op, a, b; sees busy, done, div_zero, hi, lo
//   slave  (muldiv_seq)  : the reverse
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the shared datapath (combinational).
//   div_mode : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi   : multiply upper accumulator / divide partial remainder (WIDTH+1)
//   acc_lo   : multiply lower half + remaining multiplier bits /
//              divide dividend bits being consumed + quotient bits produced
//   operand  : multiplicand magnitude / divisor magnitude
//   nxt_hi, nxt_lo : accumulator values after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        addend  = acc_lo[0] ? {1'b0, operand} : '0;
        sum     = acc_hi + addend;
        // Remainder stays below the divisor, so its top bit is free to take
        // the next dividend bit without loss.
        shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, operand};

        if (div_mode) begin
            if (!trial[WIDTH+1]) begin
                nxt_hi = trial[WIDTH:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Product bits shift down into acc_lo as multiplier bits retire.
            nxt_hi = {1'b0, sum[WIDTH:1]};
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed/unsigned multiply and divide feeding Hi/Lo.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : muldiv_if.slave (start/op/a/b in; busy/done/div_zero/hi/lo out)
// Operates on magnitudes and fixes signs at the end; one bit per RUN cycle.
//
// state | meaning
// IDLE  | waiting for start; captures op/a/b on accept
// PREP  | form magnitudes and sign flags, detect divide-by-zero
// RUN   | WIDTH iterations of the shared step datapath
// FIX   | apply sign correction and load hi/lo (or flag div_zero)
// DONE  | one-cycle done pulse
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             div_zero_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             run_last;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Magnitudes: the most negative value maps to 2^(WIDTH-1) unsigned.
    assign a_neg    = is_signed_op(op_q) & a_q[WIDTH-1];
    assign b_neg    = is_signed_op(op_q) & b_q[WIDTH-1];
    assign a_abs    = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_abs    = b_neg ? (~b_q + 1'b1) : b_q;
    assign run_last = (cnt == CNT_W'(WIDTH - 1));

    assign prod     = {acc_hi[WIDTH-1:0], acc_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign quo_fix  = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_fix  = neg_r ? (~acc_hi[WIDTH-1:0] + 1'b1) : acc_hi[WIDTH-1:0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div(op_q)),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .operand  (opnd_q),
        .nxt_hi   (step_hi),
        .nxt_lo   (step_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = PREP;
            PREP: state_nxt = (is_div(op_q) && b_q == '0) ? FIX : RUN;
            RUN:  if (run_last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            PREP, RUN, FIX: bus.busy = 1'b1;
            DONE:           bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q       <= bus.op;
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        div_zero_q <= 1'b0;
                    end
                end
                PREP: begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    dz_q   <= is_div(op_q) && (b_q == '0);
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    if (is_div(op_q)) begin
                        acc_lo <= a_abs;
                        opnd_q <= b_abs;
                    end else begin
                        acc_lo <= b_abs;
                        opnd_q <= a_abs;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (dz_q) begin
                        div_zero_q <= 1'b1;
                    end else if (is_div(op_q)) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: last committed hi/lo.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    // Results of the last wait_done.
    int           lat;
    bit           busy_ok;
    logic [W-1:0] r_hi, r_lo;
    logic         r_dz, r_busy_at_done;

    task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] eh, output logic [W-1:0] el,
                             output logic edz, output int elat);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [2*W-1:0]  p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        eh = m_hi;
        el = m_lo;
        edz = 1'b0;
        elat = W + 2;
        case (op)
            OP_MULT:  begin p = sa * sb; {eh, el} = p; end
            OP_MULTU: begin p = ua * ub; {eh, el} = p; end
            default: begin
                if (b == '0) begin
                    edz = 1'b1;
                    elat = 2;
                end else if (op == OP_DIV) begin
                    el = W'(sa / sb);
                    eh = W'(sa % sb);
                end else begin
                    el = W'(ua / ub);
                    eh = W'(ua % ub);
                end
            end
        endcase
        m_hi = eh;
        m_lo = el;
    endtask

    // Accept on the edge after this negedge; returns in the cycle after accept.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Counts cycles from the one after accept (0) until done, bounded.
    // poke pulses a divide-by-zero start request during RUN.
    task automatic wait_done(input bit poke);
        int c;
        c = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && c < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (poke) begin
                bus.start = (c == 10);
                bus.op    = OP_DIVU;
                bus.b     = '0;
            end
            @(negedge clk);
            c++;
        end
        bus.start      = 1'b0;
        lat            = c;
        r_hi           = bus.hi;
        r_lo           = bus.lo;
        r_dz           = bus.div_zero;
        r_busy_at_done = bus.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got busy/done/dz=%b, expected 000", {bus.busy, bus.done, bus.div_zero});
        end
        checks++;
        if (bus.hi !== '0 || bus.lo !== '0) begin
            failures++;
            $display("FAIL reset_hilo: got %h_%h, expected 0_0", bus.hi, bus.lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]   d_op[6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIVU, OP_DIV};
        logic [W-1:0] d_a[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000};
        logic [W-1:0] d_b[6]  = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF};
        logic [W-1:0] eh, el;
        logic         edz;
        int           elat;
        for (int i = 0; i < 6; i++) begin
            ref_model(d_op[i], d_a[i], d_b[i], eh, el, edz, elat);
            issue(d_op[i], d_a[i], d_b[i]);
            wait_done(1'b0);
            checks++;
            if (lat !== elat) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d, expected %0d", i, lat, elat);
            end
            checks++;
            if (r_hi !== eh || r_lo !== el) begin
                failures++;
                $display("FAIL dir%0d_result: got hi=%h lo=%h, expected hi=%h lo=%h", i, r_hi, r_lo, eh, el);
            end
            checks++;
            if (r_dz !== edz) begin
                failures++;
                $display("FAIL dir%0d_div_zero: got %b, expected %b", i, r_dz, edz);
            end
            checks++;
            if (!busy_ok || r_busy_at_done !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_busy: got busy_ok=%b busy_at_done=%b, expected 1 and 0", i, busy_ok, r_busy_at_done);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_done_pulse: got done=%b after pulse, expected 0", i, bus.done);
            end
        end
    endtask

    task automatic test_div_zero_hold();
        logic [W-1:0] eh, el;
        logic         edz;
        int           elat;
        ref_model(OP_DIVU, 32'd100, 32'd7, eh, el, edz, elat);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(1'b0);
        ref_model(OP_DIVU, 32'd100, 32'd0, eh, el, edz, elat);
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(1'b0);
        checks++;
        if (lat !== 2 || r_dz !== 1'b1 || r_hi !== eh || r_lo !== el) begin
            failures++;
            $display("FAIL dz_result: got lat=%0d dz=%b hi=%h lo=%h, expected lat=2 dz=1 hi=%h lo=%h", lat, r_dz, r_hi, r_lo, eh, el);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.div_zero !== 1'b1) begin
            failures++;
            $display("FAIL dz_hold: got div_zero=%b while idle, expected 1", bus.div_zero);
        end
        ref_model(OP_MULTU, 32'd5, 32'd6, eh, el, edz, elat);
        issue(OP_MULTU, 32'd5, 32'd6);
        checks++;
        if (bus.div_zero !== 1'b0) begin
            failures++;
            $display("FAIL dz_clear: got div_zero=%b after accept, expected 0", bus.div_zero);
        end
        wait_done(1'b0);
        checks++;
        if (r_hi !== eh || r_lo !== el || lat !== elat) begin
            failures++;
            $display("FAIL dz_next_op: got hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=%0d", r_hi, r_lo, lat, eh, el, elat);
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] eh, el;
        logic         edz;
        int           elat;
        ref_model(OP_DIV, 32'h80000000, 32'hFFFFFFFF, eh, el, edz, elat);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1'b1);
        checks++;
        if (lat !== elat || !busy_ok) begin
            failures++;
            $display("FAIL ign_latency: got lat=%0d busy_ok=%b, expected lat=%0d busy_ok=1", lat, busy_ok, elat);
        end
        checks++;
        if (r_hi !== eh || r_lo !== el || r_dz !== 1'b0) begin
            failures++;
            $display("FAIL ign_result: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=0", r_hi, r_lo, r_dz, eh, el);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_no_queue: got busy=%b after done, expected 0", bus.busy);
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] a, b, eh, el;
        logic         edz;
        int           elat;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'd1;
                2:       b = '1;
                3:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            ref_model(op, a, b, eh, el, edz, elat);
            issue(op, a, b);
            wait_done(1'b0);
            checks++;
            if (r_hi !== eh || r_lo !== el || r_dz !== edz) begin
                failures++;
                $display("FAIL rnd%0d op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                         i, op, a, b, r_hi, r_lo, r_dz, eh, el, edz);
            end
            checks++;
            if (lat !== elat || !busy_ok) begin
                failures++;
                $display("FAIL rnd%0d_timing: got lat=%0d busy_ok=%b, expected lat=%0d busy_ok=1", i, lat, busy_ok, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eh, el;
        logic         edz;
        int           elat;
        ref_model(OP_MULT, 32'h12345678, 32'hFEDCBA98, eh, el, edz, elat);
        issue(OP_MULT, 32'h12345678, 32'hFEDCBA98);
        wait_done(1'b0);
        // Request held from the DONE cycle: must be taken one edge later.
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'hFFFF0001;
        bus.b     = 32'd12345;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_reject: got busy=%b, expected 0", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b, expected 1", bus.busy);
        end
        bus.start = 1'b0;
        ref_model(OP_DIV, 32'hFFFF0001, 32'd12345, eh, el, edz, elat);
        wait_done(1'b0);
        checks++;
        if (r_hi !== eh || r_lo !== el || lat !== elat) begin
            failures++;
            $display("FAIL b2b_result: got hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=%0d", r_hi, r_lo, lat, eh, el, elat);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] eh, el;
        logic         edz;
        int           elat;
        bit           seen;
        issue(OP_MULT, 32'h7FFF1234, 32'h00ABCDEF);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            failures++;
            $display("FAIL rst_mid: got busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_abort: got activity after reset, expected none");
        end
        ref_model(OP_MULT, 32'hFFFFFFFF, 32'h80000000, eh, el, edz, elat);
        issue(OP_MULT, 32'hFFFFFFFF, 32'h80000000);
        wait_done(1'b0);
        checks++;
        if (r_hi !== eh || r_lo !== el || lat !== elat) begin
            failures++;
            $display("FAIL rst_recover: got hi=%h lo=%h lat=%0d, expected hi=%h lo=%h lat=%0d", r_hi, r_lo, lat, eh, el, elat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero_hold();
        test_ignore_start();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
